// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy encoding, per-stage field widths
// and ID/EX control-field bit offsets.
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  // Stage field widths
  localparam int IF_ID_CTRL_W  = 1;    // predicted-taken
  localparam int IF_ID_DATA_W  = 64;   // pc, instruction
  localparam int ID_EX_CTRL_W  = 20;
  localparam int ID_EX_DATA_W  = 133;  // pc, rs1, rs2, imm, rd
  localparam int EX_MEM_CTRL_W = 10;   // reg_write_en, mem_write, mem_read, wb_sel
  localparam int EX_MEM_DATA_W = 101;  // alu result, rs2, pc, rd
  localparam int MEM_WB_CTRL_W = 3;    // reg_write_en, wb_sel
  localparam int MEM_WB_DATA_W = 101;  // alu result, load data, pc, rd

  // ID/EX control-field layout, LSB first
  localparam int CTRL_REG_WRITE_EN_LSB = 0;
  localparam int CTRL_REG_WRITE_EN_W   = 1;
  localparam int CTRL_ALU_SEL_LSB      = 1;
  localparam int CTRL_ALU_SEL_W        = 2;
  localparam int CTRL_ALUOP_LSB        = 3;
  localparam int CTRL_ALUOP_W          = 5;
  localparam int CTRL_MEM_WRITE_LSB    = 8;
  localparam int CTRL_MEM_WRITE_W      = 3;
  localparam int CTRL_BRANCH_JUMP_LSB  = 11;
  localparam int CTRL_BRANCH_JUMP_W    = 3;
  localparam int CTRL_MEM_READ_LSB     = 14;
  localparam int CTRL_MEM_READ_W       = 4;
  localparam int CTRL_WB_SEL_LSB       = 18;
  localparam int CTRL_WB_SEL_W         = 2;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and
// NOP-zeroed control field; SKID=1 adds a skid entry so in_ready is a flop.
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 20,
  parameter int DATA_W = 133,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_state_t        state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;
      logic              ready_q;

      // in_ready is registered as (next state != TWO), cutting the stall path
      assign in_ready = ready_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          state     <= EMPTY;
          main_ctrl <= '0;
          main_data <= '0;
          skid_ctrl <= '0;
          skid_data <= '0;
          ready_q   <= 1'b1;
        end else if (flush) begin
          state     <= EMPTY;
          main_ctrl <= '0;
          ready_q   <= 1'b1;
        end else begin
          case (state)
            EMPTY: begin
              if (in_fire) begin
                state     <= ONE;
                main_ctrl <= in_ctrl;
                main_data <= in_data;
              end
            end
            ONE: begin
              if (in_fire && out_fire) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
              end else if (in_fire) begin
                state     <= TWO;
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
                ready_q   <= 1'b0;
              end else if (out_fire) begin
                state     <= EMPTY;
                main_ctrl <= '0;
              end
            end
            TWO: begin
              if (out_fire) begin
                state     <= ONE;
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
                ready_q   <= 1'b1;
              end
            end
            default: begin
              state     <= EMPTY;
              main_ctrl <= '0;
              ready_q   <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_single
      assign in_ready = ~out_valid | out_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          state     <= EMPTY;
          main_ctrl <= '0;
          main_data <= '0;
        end else if (flush) begin
          state     <= EMPTY;
          main_ctrl <= '0;
        end else if (in_fire) begin
          state     <= ONE;
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end else if (out_fire) begin
          state     <= EMPTY;
          main_ctrl <= '0;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg (SKID=1 and SKID=0),
// checked against a FIFO reference model of bounded capacity.
`default_nettype none

module tb_pipe_stage_reg;

  localparam int CW = 20;
  localparam int DW = 133;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  logic          fl1, iv1, ord1, ir1, ov1;
  logic [CW-1:0] ic1, oc1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    occ1;

  logic          fl0, iv0, ord0, ir0, ov0;
  logic [CW-1:0] ic0, oc0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    occ0;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t q1[$];
  beat_t q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
    .out_valid(ov1), .out_ready(ord1), .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0),
    .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0), .in_data(id0),
    .out_valid(ov0), .out_ready(ord0), .out_ctrl(oc0), .out_data(od0),
    .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Expected view: stage behaves as a FIFO of capacity 2 (SKID=1) or 1 (SKID=0)
  task automatic check_all();
    logic [CW-1:0] e1, e0;
    e1 = '0;
    e0 = '0;
    if (q1.size() > 0) e1 = q1[0].c;
    if (q0.size() > 0) e0 = q0[0].c;
    chk("ready1", ir1, q1.size() < 2);
    chk("valid1", ov1, q1.size() > 0);
    chk("occ1",   occ1, q1.size());
    chk("ctrl1",  oc1, e1);
    if (q1.size() > 0) chk("data1", od1, q1[0].d);
    chk("ready0", ir0, (q0.size() == 0) || ord0);
    chk("valid0", ov0, q0.size() > 0);
    chk("occ0",   occ0, q0.size());
    chk("ctrl0",  oc0, e0);
    if (q0.size() > 0) chk("data0", od0, q0[0].d);
  endtask

  task automatic model_update();
    bit pop1, push1, pop0, push0;
    pop1  = (q1.size() > 0) && ord1;
    push1 = iv1 && (q1.size() < 2);
    pop0  = (q0.size() > 0) && ord0;
    push0 = iv0 && ((q0.size() == 0) || ord0);
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (fl1) q1.delete();
      else begin
        if (pop1) void'(q1.pop_front());
        if (push1) q1.push_back('{c: ic1, d: id1});
      end
      if (fl0) q0.delete();
      else begin
        if (pop0) void'(q0.pop_front());
        if (push0) q0.push_back('{c: ic0, d: id0});
      end
    end
  endtask

  task automatic cycle();
    #3;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fl1 = 1'b0; iv1 = 1'b0; ord1 = 1'b1; ic1 = '0; id1 = '0;
    fl0 = 1'b0; iv0 = 1'b0; ord0 = 1'b1; ic0 = '0; id0 = '0;
    @(posedge clk);
    model_update();
    #1;
    cycle();
    rst = 1'b0;
    chk("rst_data1", od1, '0);
    chk("rst_data0", od0, '0);
    chk("rst_ready1", ir1, 1'b1);

    // Streaming on dut1; dut0 streams with occasional back-pressure
    for (int i = 1; i <= 8; i++) begin
      iv1 = 1'b1; ic1 = CW'(i); id1 = rnd_data(); ord1 = 1'b1;
      iv0 = 1'b1; ic0 = CW'(i); id0 = rnd_data(); ord0 = (i % 3) != 2;
      cycle();
      chk("stream_occ1_le1", occ1 <= 2'd1, 1'b1);
    end
    iv1 = 1'b0; iv0 = 1'b0; ord0 = 1'b1;
    cycle();
    cycle();

    // Stall fill and in-order drain
    ord1 = 1'b0; iv1 = 1'b1; ic1 = 20'h11; id1 = rnd_data();
    cycle();
    ic1 = 20'h22; id1 = rnd_data();
    cycle();
    chk("stall_occ", occ1, 2'd2);
    chk("stall_ready", ir1, 1'b0);
    chk("stall_head", oc1, 20'h11);
    iv1 = 1'b0;
    cycle();
    chk("stall_stable", oc1, 20'h11);
    ord1 = 1'b1;
    cycle();
    chk("drain_second", oc1, 20'h22);
    chk("drain_ready", ir1, 1'b1);
    cycle();
    cycle();

    // Flush while holding two entries and presenting 0x33
    ord1 = 1'b0; iv1 = 1'b1; ic1 = 20'h44; id1 = rnd_data();
    cycle();
    ic1 = 20'h55; id1 = rnd_data();
    cycle();
    fl1 = 1'b1; ic1 = 20'h33; id1 = rnd_data();
    cycle();
    fl1 = 1'b0; iv1 = 1'b0;
    chk("flush_valid", ov1, 1'b0);
    chk("flush_ctrl", oc1, '0);
    chk("flush_occ", occ1, 2'd0);
    chk("flush_ready", ir1, 1'b1);
    ord1 = 1'b1;
    cycle();
    cycle();

    // Bubble zeroing
    iv1 = 1'b0; ic1 = '1;
    repeat (3) cycle();

    // Reset in TWO with a beat presented
    ord1 = 1'b0; iv1 = 1'b1; ic1 = 20'h66; id1 = rnd_data();
    cycle();
    ic1 = 20'h77; id1 = rnd_data();
    cycle();
    rst = 1'b1; ic1 = 20'h88; id1 = rnd_data();
    cycle();
    rst = 1'b0; iv1 = 1'b0;
    chk("mrst_valid", ov1, 1'b0);
    chk("mrst_occ", occ1, 2'd0);
    chk("mrst_data", od1, '0);
    chk("mrst_ready", ir1, 1'b1);
    ord1 = 1'b1;
    cycle();
    cycle();

    // SKID=0 with out_ready toggling under continuous input
    for (int i = 0; i < 9; i++) begin
      iv0 = 1'b1; ic0 = CW'(20'h100 + i); id0 = rnd_data();
      ord0 = (i % 3) != 1;
      cycle();
    end
    iv0 = 1'b0; ord0 = 1'b1;
    cycle();

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      iv1 = ($urandom % 4) != 0; ord1 = ($urandom % 3) != 0;
      fl1 = ($urandom % 16) == 0; ic1 = CW'($urandom); id1 = rnd_data();
      iv0 = ($urandom % 4) != 0; ord0 = ($urandom % 3) != 0;
      fl0 = ($urandom % 16) == 0; ic0 = CW'($urandom); id0 = rnd_data();
      cycle();
    end

    iv1 = 1'b0; ord1 = 1'b1; fl1 = 1'b0;
    iv0 = 1'b0; ord0 = 1'b1; fl0 = 1'b0;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
